pll_lock_supervisor: RTL and testbench

//  Sits at the consumer side of the system PLL: drives the PLL RESET pin and watches its LOCK output.

---
 rtl/pll_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_lock_supervisor.sv | 112 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pll_pkg
// Purpose : Shared state encoding and widths for the PLL lock supervisor.
// Revision: 1.0
// ============================================================================
package pll_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4,
    ST_FAIL      = 3'd5
  } pll_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Purpose : Generic two-flop synchroniser with a parameterised reset value.
// Revision: 1.0
// ============================================================================
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module  : pll_lock_supervisor
// Purpose : Sequences PLL reset, lock acquisition and qualification, then
//           releases sys_rst; retries on timeout and re-sequences on lock loss.
// Revision: 1.0
// ============================================================================
module pll_lock_supervisor
  import pll_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 24000,
  parameter int STABLE_CYCLES = 2400,
  parameter int MAX_RETRY     = 7
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               lock_async,
  input  logic               restart_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               locked,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state_o
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  pll_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RETRY_W-1:0] retry_n, retry_inc;
  logic               lock_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk (clkin),
    .rst (rst),
    .d   (lock_async),
    .q   (lock_s)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    retry_n   = retry_cnt;
    retry_inc = (retry_cnt == {RETRY_W{1'b1}}) ? retry_cnt : retry_cnt + RETRY_W'(1);
    case (state)
      ST_PLL_RST: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == RST_LAST) state_n = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        cnt_n = cnt + CNT_W'(1);
        // A lock seen on the timeout cycle still counts as success.
        if (lock_s) begin
          state_n = ST_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_n = retry_inc;
          state_n = (int'(retry_inc) > MAX_RETRY) ? ST_FAIL : ST_PLL_RST;
        end
      end
      ST_STABLE: begin
        cnt_n = cnt + CNT_W'(1);
        if (!lock_s)                  state_n = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_n = ST_RUN;
      end
      ST_RUN:  if (!lock_s) state_n = ST_LOST;
      ST_LOST: state_n = ST_PLL_RST;
      ST_FAIL: state_n = ST_FAIL;
      default: state_n = ST_PLL_RST;
    endcase

    if (state_n != state) cnt_n = '0;

    if (restart_req) begin
      state_n = ST_PLL_RST;
      retry_n = '0;
      cnt_n   = '0;
    end
  end

  // Outputs are decoded from the next state so they switch with the state.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state     <= ST_PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry_cnt <= retry_n;
      pll_rst   <= (state_n == ST_PLL_RST) || (state_n == ST_FAIL);
      sys_rst   <= (state_n != ST_RUN);
      locked    <= (state_n == ST_RUN);
      fail      <= (state_n == ST_FAIL);
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module  : tb_pll_lock_supervisor
// Purpose : Directed self-checking bench for pll_lock_supervisor.
// Revision: 1.0
// ============================================================================
module tb_pll_lock_supervisor;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       lock_async = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_rst, sys_rst, locked, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (10),
    .MAX_RETRY     (2)
  ) dut (
    .clkin       (clkin),
    .rst         (rst),
    .lock_async  (lock_async),
    .restart_req (restart_req),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .locked      (locked),
    .fail        (fail),
    .retry_cnt   (retry_cnt),
    .state_o     (state_o)
  );

  always #5 clkin = ~clkin;

  // sys_rst must be low exactly when the FSM is in RUN.
  always @(negedge clkin) begin
    checks++;
    if ((sys_rst == 1'b0) !== (state_o == 3'd3)) begin
      failures++;
      $display("FAIL sysrst_iff_run t=%0t sys_rst=%b state=%0d", $time, sys_rst, state_o);
    end
  end

  task automatic tick();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic release_rst();
    @(negedge clkin);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic apply_reset(input logic lock_val);
    @(negedge clkin);
    rst = 1'b1;
    restart_req = 1'b0;
    lock_async = lock_val;
    @(negedge clkin);
    release_rst();
  endtask

  task automatic test_reset();
    @(negedge clkin);
    rst = 1'b1;
    lock_async = 1'b0;
    #2;
    checks++; if (pll_rst !== 1'b1)   begin failures++; $display("FAIL rst_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (sys_rst !== 1'b1)   begin failures++; $display("FAIL rst_sys_rst got=%b exp=1", sys_rst); end
    checks++; if (locked !== 1'b0)    begin failures++; $display("FAIL rst_locked got=%b exp=0", locked); end
    checks++; if (fail !== 1'b0)      begin failures++; $display("FAIL rst_fail got=%b exp=0", fail); end
    checks++; if (retry_cnt !== 4'd0) begin failures++; $display("FAIL rst_retry got=%0d exp=0", retry_cnt); end
    checks++; if (state_o !== 3'd0)   begin failures++; $display("FAIL rst_state got=%0d exp=0", state_o); end
  endtask

  task automatic test_normal_lock();
    apply_reset(1'b0);
    for (int i = 0; i < 10; i++) begin tick(); if (!pll_rst) break; end
    checks++; if (cyc != 4) begin failures++; $display("FAIL t1_pll_rst_len got=%0d exp=4", cyc); end
    repeat (3) tick();
    lock_async = 1'b1;
    for (int i = 0; i < 40; i++) begin tick(); if (!sys_rst) break; end
    checks++; if (cyc != 20) begin failures++; $display("FAIL t1_release_cycle got=%0d exp=20", cyc); end
    checks++; if (locked !== 1'b1)    begin failures++; $display("FAIL t1_locked got=%b exp=1", locked); end
    checks++; if (retry_cnt !== 4'd0) begin failures++; $display("FAIL t1_retry got=%0d exp=0", retry_cnt); end
    checks++; if (state_o !== 3'd3)   begin failures++; $display("FAIL t1_state got=%0d exp=3", state_o); end
  endtask

  task automatic test_timeout_fail();
    apply_reset(1'b0);
    repeat (24) tick();
    checks++; if (retry_cnt !== 4'd1 || state_o !== 3'd0) begin failures++; $display("FAIL t2_first_timeout retry=%0d state=%0d exp=1/0", retry_cnt, state_o); end
    repeat (47) tick();
    checks++; if (retry_cnt !== 4'd2 || fail !== 1'b0) begin failures++; $display("FAIL t2_before_fail retry=%0d fail=%b exp=2/0", retry_cnt, fail); end
    tick();
    checks++; if (fail !== 1'b1 || pll_rst !== 1'b1 || state_o !== 3'd5) begin failures++; $display("FAIL t2_fail fail=%b pll_rst=%b state=%0d exp=1/1/5", fail, pll_rst, state_o); end
    checks++; if (retry_cnt !== 4'd3) begin failures++; $display("FAIL t2_retry got=%0d exp=3", retry_cnt); end
    repeat (5) tick();
    checks++; if (fail !== 1'b1 || sys_rst !== 1'b1) begin failures++; $display("FAIL t2_fail_hold fail=%b sys_rst=%b exp=1/1", fail, sys_rst); end
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    checks++; if (state_o !== 3'd0 || retry_cnt !== 4'd0 || fail !== 1'b0 || pll_rst !== 1'b1) begin
      failures++; $display("FAIL t2_restart state=%0d retry=%0d fail=%b pll_rst=%b exp=0/0/0/1", state_o, retry_cnt, fail, pll_rst);
    end
    cyc = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (!pll_rst) break; end
    checks++; if (cyc != 4) begin failures++; $display("FAIL t2_restart_rst_len got=%0d exp=4", cyc); end
  endtask

  task automatic test_stable_glitch();
    apply_reset(1'b1);
    repeat (10) tick();
    lock_async = 1'b0;
    tick();
    lock_async = 1'b1;
    tick();
    checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL t3_in_stable got=%0d exp=2", state_o); end
    tick();
    checks++; if (state_o !== 3'd1 || sys_rst !== 1'b1) begin failures++; $display("FAIL t3_back_wait state=%0d sys_rst=%b exp=1/1", state_o, sys_rst); end
    tick();
    checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL t3_restable got=%0d exp=2", state_o); end
    for (int i = 0; i < 40; i++) begin tick(); if (!sys_rst) break; end
    checks++; if (cyc != 24) begin failures++; $display("FAIL t3_release_cycle got=%0d exp=24", cyc); end
    checks++; if (retry_cnt !== 4'd0) begin failures++; $display("FAIL t3_retry got=%0d exp=0", retry_cnt); end
  endtask

  task automatic test_run_loss();
    tick();
    lock_async = 1'b0;
    tick();
    tick();
    checks++; if (sys_rst !== 1'b0 || locked !== 1'b1) begin failures++; $display("FAIL t4_pre_loss sys_rst=%b locked=%b exp=0/1", sys_rst, locked); end
    tick();
    checks++; if (sys_rst !== 1'b1 || locked !== 1'b0 || state_o !== 3'd4) begin failures++; $display("FAIL t4_lost sys_rst=%b locked=%b state=%0d exp=1/0/4", sys_rst, locked, state_o); end
    lock_async = 1'b1;
    tick();
    checks++; if (state_o !== 3'd0 || pll_rst !== 1'b1) begin failures++; $display("FAIL t4_reseq state=%0d pll_rst=%b exp=0/1", state_o, pll_rst); end
    for (int i = 0; i < 40; i++) begin tick(); if (!sys_rst) break; end
    checks++; if (cyc != 44) begin failures++; $display("FAIL t4_rerun_cycle got=%0d exp=44", cyc); end
    checks++; if (retry_cnt !== 4'd0) begin failures++; $display("FAIL t4_retry got=%0d exp=0", retry_cnt); end
  endtask

  task automatic test_async_reset();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sys_rst !== 1'b1 || pll_rst !== 1'b1 || locked !== 1'b0 || state_o !== 3'd0) begin
      failures++; $display("FAIL t5_run_async sys_rst=%b pll_rst=%b locked=%b state=%0d exp=1/1/0/0", sys_rst, pll_rst, locked, state_o);
    end
    apply_reset(1'b0);
    repeat (24) tick();
    lock_async = 1'b1;
    repeat (7) tick();
    checks++; if (state_o !== 3'd2 || retry_cnt !== 4'd1) begin failures++; $display("FAIL t5_pre_stable state=%0d retry=%0d exp=2/1", state_o, retry_cnt); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sys_rst !== 1'b1 || pll_rst !== 1'b1 || state_o !== 3'd0 || retry_cnt !== 4'd0) begin
      failures++; $display("FAIL t5_stable_async sys_rst=%b pll_rst=%b state=%0d retry=%0d exp=1/1/0/0", sys_rst, pll_rst, state_o, retry_cnt);
    end
    release_rst();
    for (int i = 0; i < 10; i++) begin tick(); if (!pll_rst) break; end
    checks++; if (cyc != 4) begin failures++; $display("FAIL t5_cnt_cleared got=%0d exp=4", cyc); end
  endtask

  task automatic test_back_to_back();
    apply_reset(1'b0);
    repeat (24) tick();
    lock_async = 1'b1;
    for (int i = 0; i < 40; i++) begin tick(); if (state_o == 3'd3) break; end
    checks++; if (cyc != 39 || retry_cnt !== 4'd1) begin failures++; $display("FAIL t6_run_entry cyc=%0d retry=%0d exp=39/1", cyc, retry_cnt); end
    lock_async = 1'b0;
    tick();
    tick();
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    checks++; if (state_o !== 3'd0 || retry_cnt !== 4'd0) begin failures++; $display("FAIL t6_restart_prio state=%0d retry=%0d exp=0/0", state_o, retry_cnt); end
    checks++; if (sys_rst !== 1'b1 || pll_rst !== 1'b1 || locked !== 1'b0) begin failures++; $display("FAIL t6_outputs sys_rst=%b pll_rst=%b locked=%b exp=1/1/0", sys_rst, pll_rst, locked); end
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_timeout_fail();
    test_stable_glitch();
    test_run_loss();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(negedge clkin);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
